serial_adder: RTL

Bit-serial, parametrised N-bit adder/subtractor built around a single full-adder cell and a carry flip-flop. It processes one bit per clock, LSB first, under a start/busy/done handshake, and reports sum, carry-out and signed overflow. It is the area-minimal arithmetic unit for slow datapaths, where one full-adder slice replaces a WIDTH-wide ripple chain.

---
 rtl/serial_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder/subtractor.
// One full-adder slice plus a carry flop processes one bit per clock, LSB
// first, under a start/busy/done handshake. Latency is WIDTH clocks.
// Optional feature macro: SERIAL_ADDER_ACC_EN adds an 'acc' input that loads
// operand A from the current sum, turning the block into a running accumulator.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef SERIAL_ADDER_ACC_EN
    input  logic             acc,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;      // operand A, shifted right each bit
    logic [WIDTH-1:0] r_b;      // operand B (pre-inverted for subtract)
    logic [WIDTH-1:0] r_res;    // partial result, filled from the MSB side
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_cnext;
    logic [WIDTH-1:0] w_a_load;

    // A new operation may start whenever the engine is not mid-operation.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

    // The single full-adder slice.
    assign w_s     = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cnext = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

`ifdef SERIAL_ADDER_ACC_EN
    assign w_a_load = acc ? r_sum : a;
`else
    assign w_a_load = a;
`endif

    // State register; reset wins over any start on the same edge.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: IDLE -> RUN -> DONE -> (IDLE | RUN on a new start).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last)   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish the
    // result only on the final bit so partial state never reaches outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            // Subtract is a + ~b + ~cin, so the borrow-in becomes carry-in.
            r_a   <= w_a_load;
            r_b   <= sub ? ~b : b;
            r_c   <= sub ? ~cin : cin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= {w_s, r_res[WIDTH-1:1]};
            r_c   <= w_cnext;
            if (w_last) begin
                // On the MSB, r_c is still the carry into that bit.
                r_sum  <= {w_s, r_res[WIDTH-1:1]};
                r_cout <= w_cnext;
                r_ovf  <= r_c ^ w_cnext;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
